// File: rtl/arch_reg_file_spec.sv
// arch_reg_file_spec: committed + speculative register file with per-register ROB-tagged speculative flag
module arch_reg_file_spec #(
  parameter int NUM_REGS  = 32,
  parameter int DATA_W    = 64,
  parameter int RD_PORTS  = 4,
  parameter int SPC_PORTS = 2,
  parameter int CMT_PORTS = 2,
  parameter int TAG_W     = 6,
  parameter int ZERO_REG  = 1,
  parameter int IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_recover,
  input  logic [RD_PORTS-1:0]                  i_rd_en,
  input  logic [RD_PORTS-1:0][IDX_W-1:0]       i_rd_idx,
  output logic [RD_PORTS-1:0][DATA_W-1:0]      o_rd_data,
  output logic [RD_PORTS-1:0]                  o_rd_spec,
  input  logic [SPC_PORTS-1:0]                 i_spc_valid,
  input  logic [SPC_PORTS-1:0][IDX_W-1:0]      i_spc_idx,
  input  logic [SPC_PORTS-1:0][TAG_W-1:0]      i_spc_tag,
  input  logic [SPC_PORTS-1:0][DATA_W-1:0]     i_spc_data,
  input  logic [CMT_PORTS-1:0]                 i_cmt_valid,
  input  logic [CMT_PORTS-1:0][IDX_W-1:0]      i_cmt_idx,
  input  logic [CMT_PORTS-1:0][TAG_W-1:0]      i_cmt_tag,
  input  logic [CMT_PORTS-1:0][DATA_W-1:0]     i_cmt_data,
  output logic [IDX_W:0]                       o_spec_count
);
  logic [DATA_W-1:0] cmt_q [NUM_REGS];
  logic [DATA_W-1:0] cmt_d [NUM_REGS];
  logic [DATA_W-1:0] spc_q [NUM_REGS];
  logic [DATA_W-1:0] spc_d [NUM_REGS];
  logic [TAG_W-1:0]  tag_q [NUM_REGS];
  logic [TAG_W-1:0]  tag_d [NUM_REGS];
  logic [NUM_REGS-1:0] flag_q, flag_d, spw, clr;
  logic [RD_PORTS-1:0][DATA_W-1:0] rd_data_d;
  logic [RD_PORTS-1:0] rd_spec_d;
  always_comb begin
    cmt_d = cmt_q;
    spc_d = spc_q;
    tag_d = tag_q;
    spw = '0;
    clr = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (ZERO_REG == 0 || r != 0) begin
        // ascending port order lets the highest port win on index conflicts
        for (int p = 0; p < SPC_PORTS; p++)
          if (i_spc_valid[p] && !i_recover && i_spc_idx[p] == IDX_W'(r)) begin
            spc_d[r] = i_spc_data[p];
            tag_d[r] = i_spc_tag[p];
            spw[r] = 1'b1;
          end
        for (int p = 0; p < CMT_PORTS; p++)
          if (i_cmt_valid[p] && i_cmt_idx[p] == IDX_W'(r)) begin
            cmt_d[r] = i_cmt_data[p];
            clr[r] = clr[r] | (flag_q[r] && tag_q[r] == i_cmt_tag[p]);
          end
      end
    end
    flag_d = i_recover ? '0 : spw | (flag_q & ~clr);
    rd_data_d = o_rd_data;
    rd_spec_d = o_rd_spec;
    for (int q = 0; q < RD_PORTS; q++) begin
      if (i_rd_en[q]) begin
        rd_data_d[q] = '0;
        rd_spec_d[q] = 1'b0;
        for (int r = 0; r < NUM_REGS; r++)
          if (i_rd_idx[q] == IDX_W'(r)) begin
            rd_data_d[q] = flag_d[r] ? spc_d[r] : cmt_d[r];
            rd_spec_d[q] = flag_d[r];
          end
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cmt_q <= '{default: '0};
      spc_q <= '{default: '0};
      tag_q <= '{default: '0};
      flag_q <= '0;
      o_rd_data <= '0;
      o_rd_spec <= '0;
      o_spec_count <= '0;
    end else begin
      cmt_q <= cmt_d;
      spc_q <= spc_d;
      tag_q <= tag_d;
      flag_q <= flag_d;
      o_rd_data <= rd_data_d;
      o_rd_spec <= rd_spec_d;
      o_spec_count <= (IDX_W+1)'($countones(flag_d));
    end
  end
endmodule

// File: tb/tb_arch_reg_file_spec.sv
// tb_arch_reg_file_spec: directed plan plus random traffic against an array-based reference model
module tb_arch_reg_file_spec;
  localparam int NR = 32, DW = 64, RP = 4, SP = 2, CP = 2, TW = 6, IW = 5;
  logic clk = 1'b0, rst, rec;
  logic [RP-1:0] rd_en;
  logic [RP-1:0][IW-1:0] rd_idx;
  logic [RP-1:0][DW-1:0] rd_data;
  logic [RP-1:0] rd_spec;
  logic [SP-1:0] s_v;
  logic [SP-1:0][IW-1:0] s_i;
  logic [SP-1:0][TW-1:0] s_t;
  logic [SP-1:0][DW-1:0] s_d;
  logic [CP-1:0] c_v;
  logic [CP-1:0][IW-1:0] c_i;
  logic [CP-1:0][TW-1:0] c_t;
  logic [CP-1:0][DW-1:0] c_d;
  logic [IW:0] cnt;
  arch_reg_file_spec dut (
    .i_clk(clk), .i_rst(rst), .i_recover(rec),
    .i_rd_en(rd_en), .i_rd_idx(rd_idx), .o_rd_data(rd_data), .o_rd_spec(rd_spec),
    .i_spc_valid(s_v), .i_spc_idx(s_i), .i_spc_tag(s_t), .i_spc_data(s_d),
    .i_cmt_valid(c_v), .i_cmt_idx(c_i), .i_cmt_tag(c_t), .i_cmt_data(c_d),
    .o_spec_count(cnt)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] m_cmt [NR];
  logic [DW-1:0] m_spc [NR];
  logic [TW-1:0] m_tag [NR];
  bit m_flag [NR];
  logic [DW-1:0] e_rd [RP];
  bit e_sp [RP];
  int e_cnt;
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string t, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", t, got, exp);
  endtask
  // applies this cycle's inputs to the model as a list of register-file rules
  task automatic model_step();
    bit spw [NR];
    bit hit [NR];
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        m_cmt[r] = '0; m_spc[r] = '0; m_tag[r] = '0; m_flag[r] = 0;
      end
      for (int q = 0; q < RP; q++) begin e_rd[q] = '0; e_sp[q] = 0; end
      e_cnt = 0;
      return;
    end
    for (int r = 0; r < NR; r++) begin spw[r] = 0; hit[r] = 0; end
    for (int p = 0; p < CP; p++)
      if (c_v[p] && c_i[p] != 0 && m_flag[c_i[p]] && m_tag[c_i[p]] == c_t[p]) hit[c_i[p]] = 1;
    if (!rec)
      for (int p = 0; p < SP; p++)
        if (s_v[p] && s_i[p] != 0) begin
          m_spc[s_i[p]] = s_d[p]; m_tag[s_i[p]] = s_t[p]; spw[s_i[p]] = 1;
        end
    for (int p = 0; p < CP; p++)
      if (c_v[p] && c_i[p] != 0) m_cmt[c_i[p]] = c_d[p];
    e_cnt = 0;
    for (int r = 0; r < NR; r++) begin
      if (rec) m_flag[r] = 0;
      else if (spw[r]) m_flag[r] = 1;
      else if (hit[r]) m_flag[r] = 0;
      e_cnt += int'(m_flag[r]);
    end
    for (int q = 0; q < RP; q++)
      if (rd_en[q]) begin
        e_sp[q] = m_flag[rd_idx[q]];
        e_rd[q] = e_sp[q] ? m_spc[rd_idx[q]] : m_cmt[rd_idx[q]];
      end
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    for (int q = 0; q < RP; q++) begin
      chk($sformatf("rd_data%0d", q), rd_data[q], e_rd[q]);
      chk($sformatf("rd_spec%0d", q), DW'(rd_spec[q]), DW'(e_sp[q]));
    end
    chk("spec_count", DW'(cnt), DW'(e_cnt));
  endtask
  task automatic idle();
    rst = 0; rec = 0; rd_en = '0; rd_idx = '0;
    s_v = '0; s_i = '0; s_t = '0; s_d = '0;
    c_v = '0; c_i = '0; c_t = '0; c_d = '0;
  endtask
  task automatic spc(input int p, input int idx, input int tag, input logic [DW-1:0] d);
    s_v[p] = 1; s_i[p] = IW'(idx); s_t[p] = TW'(tag); s_d[p] = d;
  endtask
  task automatic cmt(input int p, input int idx, input int tag, input logic [DW-1:0] d);
    c_v[p] = 1; c_i[p] = IW'(idx); c_t[p] = TW'(tag); c_d[p] = d;
  endtask
  task automatic rd(input int q, input int idx);
    rd_en[q] = 1; rd_idx[q] = IW'(idx);
  endtask
  initial begin
    idle();
    rst = 1;
    tick(); tick();
    idle(); rd(0, 5); tick();
    chk("reset_r5", rd_data[0], 0);
    idle(); spc(0, 3, 7, 'hAA); rd(0, 3); tick();
    chk("spec_r3_data", rd_data[0], 'hAA);
    chk("spec_r3_count", DW'(cnt), 1);
    idle(); cmt(0, 3, 7, 'hAA); rd(0, 3); tick();
    chk("commit_r3_spec", DW'(rd_spec[0]), 0);
    chk("commit_r3_count", DW'(cnt), 0);
    idle(); spc(0, 3, 7, 'h10); tick();
    idle(); spc(1, 3, 9, 'h20); tick();
    idle(); cmt(0, 3, 7, 'h30); rd(1, 3); tick();
    chk("stale_tag_count", DW'(cnt), 1);
    chk("stale_tag_data", rd_data[1], 'h20);
    idle(); cmt(1, 3, 9, 'h40); rd(1, 3); tick();
    chk("young_tag_count", DW'(cnt), 0);
    idle(); spc(0, 4, 1, 1); spc(1, 6, 2, 2); cmt(0, 4, 0, 5); tick();
    idle(); rec = 1; spc(0, 8, 3, 3); cmt(0, 6, 0, 'h11); rd(0, 4); rd(1, 6); rd(2, 8); tick();
    chk("recover_count", DW'(cnt), 0);
    chk("recover_r4", rd_data[0], 5);
    chk("recover_r6", rd_data[1], 'h11);
    chk("recover_r8", rd_data[2], 0);
    idle(); spc(0, 2, 1, 1); spc(1, 2, 2, 2); rd(3, 2); tick();
    chk("spc_conflict", rd_data[3], 2);
    idle(); cmt(0, 2, 2, 9); spc(0, 2, 5, 3); rd(3, 2); tick();
    chk("cmt_vs_spc_spec", DW'(rd_spec[3]), 1);
    idle(); spc(0, 0, 1, 'hFF); cmt(0, 0, 1, 'hFF); rd(0, 0); tick();
    chk("zero_reg", rd_data[0], 0);
    chk("zero_count", DW'(cnt), 1);
    idle(); rst = 1; spc(0, 9, 1, 'h55); cmt(0, 10, 1, 'h66); rd(0, 9); rd(1, 10); tick();
    chk("midrst_data", rd_data[0], 0);
    chk("midrst_count", DW'(cnt), 0);
    idle(); rd(0, 9); rd(1, 10); tick();
    for (int i = 0; i < 400; i++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      rec = ($urandom_range(0, 19) == 0);
      for (int p = 0; p < SP; p++)
        if ($urandom_range(0, 1)) spc(p, $urandom_range(0, 7), $urandom_range(0, 3), {$urandom, $urandom});
      for (int p = 0; p < CP; p++)
        if ($urandom_range(0, 1)) cmt(p, $urandom_range(0, 7), $urandom_range(0, 3), {$urandom, $urandom});
      for (int q = 0; q < RP; q++)
        if ($urandom_range(0, 3) != 0) rd(q, $urandom_range(0, 8));
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
